stack_mem_unit: RTL and testbench

- Load/store sequencer between the stack CPU execute stage and the 32x8 data RAM.
- Accepts load/store requests popped from the operand stack and drives the RAM's registered-read / synchronous-write port pair.
- Captures load data and presents it on a valid/ready response for the stack push.
- Optionally clears the whole RAM after reset.

---
 rtl/stack_mem_unit_pkg.sv | 13 +
 rtl/stack_mem_unit_if.sv | 26 ++
 rtl/stack_mem_unit.sv | 109 ++++++++++
 tb/tb_stack_mem_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_mem_unit_pkg.sv
// Shared constants for the stack CPU load/store path.
//   AW/DW/DEPTH : data RAM geometry (32 x 8, DEPTH == 2**AW)
//   INIT..RSP   : sequencer state encoding
package stack_pkg;
  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int DEPTH = 32;

  localparam logic [1:0] INIT    = 2'd0;
  localparam logic [1:0] IDLE    = 2'd1;
  localparam logic [1:0] RD_WAIT = 2'd2;
  localparam logic [1:0] RSP     = 2'd3;
endpackage

// File: rtl/stack_mem_unit_if.sv
// Request/response bus between the execute stage and stack_mem_unit.
//   req_valid/req_ready/req_store/req_addr/req_wdata : load/store request
//   rsp_valid/rsp_ready/rsp_data                     : load result to the stack
// master = execute stage, slave = stack_mem_unit.
interface stack_mem_unit_if
  import stack_pkg::*;
  ();
  logic          req_valid;
  logic          req_ready;
  logic          req_store;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;

  modport master (
    output req_valid, req_store, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_store, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/stack_mem_unit.sv
// Load/store sequencer between the stack CPU execute stage and the 32x8
// data RAM (registered read, synchronous write). Optionally clears the
// whole RAM after reset.
//
// Ports:
//   clk, rst   : system clock, synchronous active-high reset
//   bus        : request/response interface (slave side)
//   init_busy  : clear sweep in progress (registered)
//   ram_radr   : RAM read address, registered by the RAM on clk
//   ram_rdata  : RAM read data, valid the cycle after ram_radr is sampled
//   ram_wadr/ram_wdata/ram_wen : RAM write port
//
// state   | meaning
// --------+----------------------------------------------------
// INIT    | clear sweep, one word per cycle, requests stalled
// IDLE    | accept loads/stores; stores complete in this cycle
// RD_WAIT | RAM read in flight; rdata captured at end of cycle
// RSP     | load result held on rsp_* until rsp_ready
module stack_mem_unit
  import stack_pkg::*;
#(
  parameter int            CLEAR_ON_RESET = 1,
  parameter logic [DW-1:0] CLEAR_VALUE    = 8'h00
) (
  input  logic          clk,
  input  logic          rst,
  stack_mem_unit_if.slave bus,
  output logic          init_busy,
  output logic [AW-1:0] ram_radr,
  input  logic [DW-1:0] ram_rdata,
  output logic [AW-1:0] ram_wadr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_wen
);

  logic [1:0]    state;
  logic [AW-1:0] clr_cnt;
  logic [AW-1:0] lat_addr;
  logic          rsp_valid_q;
  logic [DW-1:0] rsp_data_q;
  logic          init_busy_q;
  logic          accept;

  // Gating with rst keeps the RAM write port quiet during the reset cycle,
  // whatever state the flops held before it.
  assign accept = bus.req_valid && bus.req_ready;

  always_comb begin
    bus.req_ready = (state == IDLE) && !rst;
    ram_radr      = (state == IDLE) ? bus.req_addr : lat_addr;
    ram_wen       = 1'b0;
    ram_wadr      = bus.req_addr;
    ram_wdata     = bus.req_wdata;
    if (!rst) begin
      if (state == INIT) begin
        ram_wen   = 1'b1;
        ram_wadr  = clr_cnt;
        ram_wdata = CLEAR_VALUE;
      end else if (accept && bus.req_store) begin
        ram_wen = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= (CLEAR_ON_RESET != 0) ? INIT : IDLE;
      clr_cnt     <= '0;
      lat_addr    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      init_busy_q <= (CLEAR_ON_RESET != 0);
    end else begin
      case (state)
        INIT: begin
          clr_cnt <= clr_cnt + 1'b1;
          // Stop on the last word so the counter never wraps into a second pass.
          if (clr_cnt == AW'(DEPTH - 1)) begin
            state       <= IDLE;
            init_busy_q <= 1'b0;
          end
        end
        IDLE: begin
          if (accept && !bus.req_store) begin
            lat_addr <= bus.req_addr;
            state    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          rsp_data_q  <= ram_rdata;
          rsp_valid_q <= 1'b1;
          state       <= RSP;
        end
        RSP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign init_busy     = init_busy_q;

endmodule

// File: tb/tb_stack_mem_unit.sv
// Self-checking bench for stack_mem_unit: behavioural RAM, reference memory
// array, and a scoreboard of expected load results checked by a monitor.
module tb_stack_mem_unit;
  import stack_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stack_mem_unit_if bus();

  logic          init_busy;
  logic [AW-1:0] ram_radr;
  logic [DW-1:0] ram_rdata;
  logic [AW-1:0] ram_wadr;
  logic [DW-1:0] ram_wdata;
  logic          ram_wen;

  stack_mem_unit #(.CLEAR_ON_RESET(1), .CLEAR_VALUE(8'h00)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .init_busy (init_busy),
    .ram_radr  (ram_radr),
    .ram_rdata (ram_rdata),
    .ram_wadr  (ram_wadr),
    .ram_wdata (ram_wdata),
    .ram_wen   (ram_wen)
  );

  // Behavioural RAM, preloaded with FF so the clear sweep is visible.
  logic [DW-1:0] ram [DEPTH];
  bit ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= 8'hFF;
      ram_loaded <= 1'b1;
    end else if (ram_wen) begin
      ram[ram_wadr] <= ram_wdata;
    end
    ram_rdata <= ram[ram_radr];
  end

  // Reference model and scoreboard
  logic [DW-1:0] ref_mem [DEPTH];
  typedef struct { logic [DW-1:0] data; int cyc; } exp_t;
  exp_t q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc++;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // rsp_ready driver
  bit rand_mode   = 1'b0;
  bit ready_force = 1'b1;
  always @(posedge clk) begin
    #2;
    bus.rsp_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_force;
  end

  // Monitor: checks latency on the rising edge of rsp_valid, and data every
  // cycle rsp_valid is up (covers stability while stalled); pops on handshake.
  bit prev_v = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (bus.rsp_valid) begin
        if (q.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          if (!prev_v) chk("load_latency", cyc, q[0].cyc + 2);
          chk("rsp_data", bus.rsp_data, q[0].data);
          if (bus.rsp_ready) void'(q.pop_front());
        end
      end
      prev_v = bus.rsp_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ref();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
  endtask

  task automatic do_req(bit st, logic [AW-1:0] a, logic [DW-1:0] d);
    bit done = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_store = st;
    bus.req_addr  = a;
    bus.req_wdata = d;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        done = 1'b1;
        if (st) begin
          chk("store_wen", ram_wen, 1);
          chk("store_wadr", ram_wadr, a);
          chk("store_wdata", ram_wdata, d);
          ref_mem[a] = d;
        end else begin
          chk("load_radr", ram_radr, a);
          q.push_back('{data: ref_mem[a], cyc: cyc});
        end
      end
      step();
    end
    if (!done) chk("req_timeout", 0, 1);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 500 && q.size() > 0; k++) step();
    chk("drain_timeout", q.size(), 0);
  endtask

  task automatic wait_valid();
    bit got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = bus.rsp_valid;
      if (!got) step();
    end
    chk("rsp_valid_seen", got, 1);
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    q.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_wen", ram_wen, 0);
      chk("rst_ready", bus.req_ready, 0);
      step();
    end
    rst = 1'b0;
    clear_ref();
  endtask

  // Runs from the first cycle after reset deasserts through the first IDLE cycle.
  task automatic sweep_check(bit with_req);
    if (with_req) begin
      bus.req_valid = 1'b1;
      bus.req_store = 1'b1;
      bus.req_addr  = 5'd20;
      bus.req_wdata = 8'h5A;
    end
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      chk("init_busy_hi", init_busy, 1);
      chk("init_wen", ram_wen, 1);
      chk("init_wadr", ram_wadr, i);
      chk("init_wdata", ram_wdata, 8'h00);
      chk("init_ready", bus.req_ready, 0);
      chk("init_rsp_valid", bus.rsp_valid, 0);
      step();
    end
    @(negedge clk);
    chk("init_busy_lo", init_busy, 0);
    chk("idle_ready", bus.req_ready, 1);
    if (with_req) begin
      chk("first_idle_wen", ram_wen, 1);
      chk("first_idle_wadr", ram_wadr, 20);
      chk("first_idle_wdata", ram_wdata, 8'h5A);
      ref_mem[20] = 8'h5A;
    end
    step();
    bus.req_valid = 1'b0;
  endtask

  initial begin
    int c0;
    bus.req_valid = 1'b0;
    bus.req_store = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'hFF;

    // Reset and clear sweep
    do_reset(2);
    @(negedge clk);
    chk("reset_init_busy", init_busy, 1);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_rsp_data", bus.rsp_data, 0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sweep_check(1'b0);

    do_req(1'b0, 5'd0, 8'h00);
    do_req(1'b0, 5'd15, 8'h00);
    do_req(1'b0, 5'd31, 8'h00);
    wait_drain();

    // Store then load same address next cycle
    do_req(1'b1, 5'd5, 8'hA5);
    do_req(1'b0, 5'd5, 8'h00);
    wait_drain();

    // Load with stalled rsp_ready
    do_req(1'b1, 5'd9, 8'h3C);
    ready_force = 1'b0;
    do_req(1'b0, 5'd9, 8'h00);
    wait_valid();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall_valid", bus.rsp_valid, 1);
      chk("stall_data", bus.rsp_data, 8'h3C);
      chk("stall_ready", bus.req_ready, 0);
      step();
    end
    ready_force = 1'b1;
    @(negedge clk);
    chk("hs_cycle_ready", bus.req_ready, 0);
    step();
    @(negedge clk);
    chk("after_hs_ready", bus.req_ready, 1);
    step();
    wait_drain();

    // Back-to-back stores
    c0 = cyc;
    for (int i = 0; i < 8; i++) do_req(1'b1, AW'(i), DW'(8'h10 + i));
    chk("store_burst_cycles", cyc - c0, 8);
    for (int i = 0; i < 8; i++) do_req(1'b0, AW'(i), 8'h00);
    wait_drain();

    // Randomized traffic with random rsp_ready
    rand_mode = 1'b1;
    for (int n = 0; n < 150; n++) begin
      do_req(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
             DW'($urandom_range(0, 255)));
    end
    wait_drain();
    rand_mode   = 1'b0;
    ready_force = 1'b1;
    step();

    // Reset while holding a response, then request during INIT
    ready_force = 1'b0;
    do_req(1'b1, 5'd12, 8'h77);
    do_req(1'b0, 5'd12, 8'h00);
    wait_valid();
    chk("pre_rst_data", bus.rsp_data, 8'h77);
    step();
    do_reset(1);
    ready_force = 1'b1;
    sweep_check(1'b1);
    do_req(1'b0, 5'd20, 8'h00);
    do_req(1'b0, 5'd12, 8'h00);
    do_req(1'b0, 5'd5, 8'h00);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
